// File: rtl/mul_rr_arbiter_if.sv
// Requester-side bundle for the shared multiplier arbiter: operand handshake
// in, one-hot tagged product responses out.
interface mul_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_product;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_product
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_product
  );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Round-robin front end sharing one external pipelined 16x16 signed multiplier
// among N requesters; a tag pipeline routes each product back to its issuer.
module mul_rr_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  mul_rr_arbiter_if.slave     bus,
  output logic signed [15:0]  mul_a,
  output logic signed [15:0]  mul_b,
  input  logic signed [31:0]  mul_product,
  output logic                busy
);

  // Returns {found, index} of the first set bit at or after p, wrapping mod N.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] g;
    int            j;
    found = 1'b0;
    g     = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(p) + k) % N;
      if (!found && v[j]) begin
        found = 1'b1;
        g     = IW'(j);
      end
    end
    return {found, g};
  endfunction

  logic [IW-1:0] r_ptr;
  logic [LAT-1:0] r_vld_p;
  logic [IW-1:0]  r_tag_p [LAT];

  logic [IW:0]   w_pick;
  logic          w_grant;
  logic [IW-1:0] w_gidx;

  // Issue stage: combinational grant and operand steering.
  always_comb begin
    w_pick        = rr_pick(bus.req_valid, r_ptr);
    w_grant       = en && !rst && w_pick[IW];
    w_gidx        = w_pick[IW-1:0];
    bus.req_ready = '0;
    mul_a         = '0;
    mul_b         = '0;
    if (w_grant) begin
      bus.req_ready[w_gidx] = 1'b1;
      mul_a = bus.req_a[16*w_gidx +: 16];
      mul_b = bus.req_b[16*w_gidx +: 16];
    end
  end

  // Control: pointer and valid pipeline, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_vld_p <= '0;
    end else begin
      if (w_grant)
        r_ptr <= (w_gidx == IW'(N-1)) ? '0 : w_gidx + 1'b1;
      r_vld_p[0] <= w_grant;
      for (int s = 1; s < LAT; s++)
        r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  // Tag stages p0..p(LAT-1): qualified by r_vld_p, so no reset needed.
  always_ff @(posedge clk) begin
    r_tag_p[0] <= w_gidx;
    for (int s = 1; s < LAT; s++)
      r_tag_p[s] <= r_tag_p[s-1];
  end

  // Response stage: product passes straight through under the last-stage valid.
  always_comb begin
    bus.resp_valid   = '0;
    bus.resp_product = '0;
    if (r_vld_p[LAT-1]) begin
      bus.resp_valid[r_tag_p[LAT-1]] = 1'b1;
      bus.resp_product               = mul_product;
    end
  end

  assign busy = |r_vld_p;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Bench for mul_rr_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a queue-based round-robin model.
module tb_mul_rr_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_product;
  logic busy;

  mul_rr_arbiter_if #(.N(N)) bus ();

  mul_rr_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered multiplier wrapper: input registers then output register.
  logic signed [15:0] m_ra, m_rb;
  logic signed [31:0] m_rp;
  always @(posedge clk) begin
    m_ra <= mul_a;
    m_rb <= mul_b;
    m_rp <= m_ra * m_rb;
  end
  assign mul_product = m_rp;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer as an integer, in-flight ops as a due-time queue.
  typedef struct { int due; int idx; logic [31:0] p; } ent_t;
  ent_t q[$];
  int   m_ptr = 0;
  int   cyc   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int   g;
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  exp_rv;
      logic [31:0]   exp_prod;
      logic signed [15:0] ea, eb;
      longint pr;
      g = -1;
      if (!rst && en)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = bus.req_a[16*g +: 16];
        eb = bus.req_b[16*g +: 16];
      end
      chk("model_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("model_mul_a", 32'(mul_a), 32'(ea));
      chk("model_mul_b", 32'(mul_b), 32'(eb));
      exp_rv   = '0;
      exp_prod = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rv[q[0].idx] = 1'b1;
        exp_prod = q[0].p;
      end
      chk("model_resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      chk("model_resp_product", bus.resp_product, exp_prod);
      chk("model_busy", 32'(busy), 32'(q.size() > 0));
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (rst) begin
        q.delete();
        m_ptr = 0;
      end else if (g >= 0) begin
        pr = longint'(ea) * longint'(eb);
        q.push_back('{due: cyc + LAT, idx: g, p: pr[31:0]});
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    en  = 1'b0;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic single_op(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    tick();
    bus.req_valid = oh;
    set_op(i, a, b);
    @(negedge clk);
    chk("corner_ready", 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    chk("corner_resp_valid", 32'(bus.resp_valid), 32'(oh));
    chk("corner_product", bus.resp_product, exp);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_random(input int ncyc, input int pv);
    logic [N-1:0] acc;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] || acc[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < pv);
          set_op(i, rnd_op(), rnd_op());
        end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] oh;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // Reset values.
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_resp_product", bus.resp_product, 32'h0);

    // Single op 3 * -5.
    tick();
    bus.req_valid = 4'b0001;
    set_op(0, 16'd3, 16'hFFFB);
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    chk("single_mul_a", 32'(mul_a), 32'h3);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_busy1", 32'(busy), 32'h1);
    chk("single_no_early_resp", 32'(bus.resp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("single_product", bus.resp_product, 32'hFFFF_FFF1);
    chk("single_busy2", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    chk("single_busy_off", 32'(busy), 32'h0);

    // All four valid: grants and responses rotate 0..3.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'(i + 1), 16'd10);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 8) begin
        oh = '0;
        oh[k % 4] = 1'b1;
        chk("rr_grant", 32'(bus.req_ready), 32'(oh));
      end
      if (k >= 2 && k < 10) begin
        oh = '0;
        oh[(k - 2) % 4] = 1'b1;
        chk("rr_resp_valid", 32'(bus.resp_valid), 32'(oh));
        chk("rr_product", bus.resp_product, 32'(10 * ((k - 2) % 4 + 1)));
      end
    end

    // Fairness after a partial round: last grant 1, then 0011 grants 0 then 1.
    do_reset();
    bus.req_valid = 4'b0010;
    set_op(0, 16'd2, 16'd2);
    set_op(1, 16'd4, 16'd4);
    @(negedge clk);
    chk("fair_first", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("fair_wrap0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("fair_then1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    // Arithmetic corners.
    single_op(0, 16'h8000, 16'h8000, 32'h4000_0000);
    single_op(1, 16'h7FFF, 16'h8000, 32'hC000_8000);
    single_op(2, 16'h0000, 16'd1234, 32'h0000_0000);
    single_op(3, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF);

    // en drop with two ops in flight.
    do_reset();
    bus.req_valid = 4'b1100;
    set_op(2, 16'd7, 16'd3);
    set_op(3, 16'hFFFE, 16'd9);
    @(negedge clk);
    chk("endrop_grant2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("endrop_grant3", 32'(bus.req_ready), 32'h8);
    tick();
    en = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("endrop_no_grant", 32'(bus.req_ready), 32'h0);
    chk("endrop_resp2", 32'(bus.resp_valid), 32'h4);
    chk("endrop_prod2", bus.resp_product, 32'd21);
    tick();
    @(negedge clk);
    chk("endrop_no_grant2", 32'(bus.req_ready), 32'h0);
    chk("endrop_resp3", 32'(bus.resp_valid), 32'h8);
    chk("endrop_prod3", bus.resp_product, 32'hFFFF_FFEE);
    chk("endrop_busy", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    chk("endrop_busy_off", 32'(busy), 32'h0);
    tick();
    bus.req_valid = '0;
    en = 1'b1;

    // Reset mid-flight discards the op and restores priority to 0.
    do_reset();
    bus.req_valid = 4'b0010;
    set_op(1, 16'd5, 16'd5);
    @(negedge clk);
    chk("rstmid_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_no_resp_a", 32'(bus.resp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("rstmid_no_resp_b", 32'(bus.resp_valid), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    tick();
    bus.req_valid = 4'b0111;
    set_op(0, 16'd1, 16'd1);
    set_op(2, 16'd3, 16'd3);
    @(negedge clk);
    chk("rstmid_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;

    // Randomized traffic at several densities.
    do_reset();
    run_random(1500, 50);
    run_random(600, 90);
    run_random(600, 20);
    tick();
    rst = 1'b0;
    en = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
